// File: rtl/iq_pkg.sv
// Shared issue-queue parameters and helpers (used by allocator, issue queue, arbiter, wakeup).
package iq_pkg;

    localparam int CIQ_DEPTH  = 16;
    localparam int DECODE_NUM = 4;
    localparam int ISSUE_NUM  = 4;
    localparam int IQ_ADDR_W  = $clog2(CIQ_DEPTH);
    localparam int IQ_CNT_W   = $clog2(CIQ_DEPTH + 1);

    typedef logic [IQ_ADDR_W-1:0] iq_addr_t;
    typedef logic [CIQ_DEPTH-1:0] iq_mask_t;
    typedef logic [IQ_CNT_W-1:0]  iq_cnt_t;

    function automatic iq_cnt_t popcount(input iq_mask_t v);
        iq_cnt_t n;
        n = '0;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            n = n + iq_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_free_finder.sv
// Combinational first-N-zeros priority encoder: addr_o[k] is the k-th lowest free entry.
module iq_free_finder
    import iq_pkg::*;
(
    input  iq_mask_t                   busy_i,
    output iq_addr_t [DECODE_NUM-1:0]  addr_o
);

    iq_cnt_t seen;

    // Slots beyond the number of free entries keep 0; callers gate them with free_cnt.
    always_comb begin
        addr_o = '0;
        seen   = '0;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (!busy_i[i]) begin
                for (int k = 0; k < DECODE_NUM; k++) begin
                    if (seen == iq_cnt_t'(k)) begin
                        addr_o[k] = iq_addr_t'(i);
                    end
                end
                seen = seen + iq_cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/iq_alloc.sv
// CIQ entry allocator: busy bitmap, all-or-nothing group allocation, grant release, flush.
// Optional stall perf counter enabled by defining IQ_ALLOC_PERF_EN.
module iq_alloc
    import iq_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DECODE_NUM-1:0]      dec_valid,
    output logic                       alloc_ready,
    output iq_addr_t [DECODE_NUM-1:0]  free_addr,
    output logic [DECODE_NUM-1:0]      free_valid,
    input  iq_addr_t [ISSUE_NUM-1:0]   arbit_addr,
    input  logic [ISSUE_NUM-1:0]       arbit_grant,
    input  logic                       flush,
    output iq_cnt_t                    free_cnt,
    output logic [31:0]                stall_cycles
);

    iq_mask_t busy_q, busy_d;
    iq_cnt_t  free_cnt_q, free_cnt_d;
    iq_mask_t alloc_mask, rel_mask;

    iq_free_finder u_finder (
        .busy_i (busy_q),
        .addr_o (free_addr)
    );

    // Ready depends on registered count and flush only, never on dec_valid.
    assign alloc_ready = (free_cnt_q >= iq_cnt_t'(DECODE_NUM)) && !flush;
    assign free_valid  = dec_valid & {DECODE_NUM{alloc_ready}};
    assign free_cnt    = free_cnt_q;

    always_comb begin
        alloc_mask = '0;
        rel_mask   = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            if (free_valid[k]) alloc_mask[free_addr[k]] = 1'b1;
        end
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (arbit_grant[j]) rel_mask[arbit_addr[j]] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~rel_mask) | alloc_mask;
        end
        free_cnt_d = iq_cnt_t'(CIQ_DEPTH) - popcount(busy_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            free_cnt_q <= iq_cnt_t'(CIQ_DEPTH);
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
        end
    end

`ifdef IQ_ALLOC_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (|dec_valid && !alloc_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    a_alloc_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_mask & busy_q) == '0);

    a_cnt_matches_busy: assert property (@(posedge clk) disable iff (!rst_n)
        free_cnt_q == iq_cnt_t'(CIQ_DEPTH) - popcount(busy_q));

    for (genvar j = 0; j < ISSUE_NUM; j++) begin : g_rel_chk
        a_release_busy: assert property (@(posedge clk) disable iff (!rst_n)
            arbit_grant[j] |-> busy_q[arbit_addr[j]]);
    end

endmodule

// File: tb/tb_iq_alloc.sv
// Bench for iq_alloc: directed vector table, reset-mid-burst sequence, randomized run vs reference model.
module tb_iq_alloc;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       dec_valid = '0;
    logic             alloc_ready;
    logic [3:0][3:0]  free_addr;
    logic [3:0]       free_valid;
    logic [3:0][3:0]  arbit_addr = '0;
    logic [3:0]       arbit_grant = '0;
    logic             flush = 1'b0;
    logic [4:0]       free_cnt;
    logic [31:0]      stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    bit          busy_m[16];
    logic [31:0] stall_m;
    logic [3:0]  exp_q[$];

    typedef struct {
        logic [3:0]  dv;
        logic [3:0]  gv;
        logic [15:0] ga;
        logic        fl;
        int          cnt;
        logic        rdy;
        logic [15:0] addr;
        logic [3:0]  fv;
    } vec_t;

    vec_t tab[17];

    iq_alloc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .alloc_ready  (alloc_ready),
        .free_addr    (free_addr),
        .free_valid   (free_valid),
        .arbit_addr   (arbit_addr),
        .arbit_grant  (arbit_grant),
        .flush        (flush),
        .free_cnt     (free_cnt),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        stall_m = '0;
    endtask

    task automatic free_list(output int fl_q[$]);
        fl_q = {};
        for (int i = 0; i < 16; i++) if (!busy_m[i]) fl_q.push_back(i);
    endtask

    task automatic drive(input logic [3:0] dv, input logic [3:0] gv, input logic [15:0] ga, input logic fl);
        @(negedge clk);
        dec_valid   = dv;
        arbit_grant = gv;
        for (int j = 0; j < 4; j++) arbit_addr[j] = ga[4*j +: 4];
        flush       = fl;
        #1;
    endtask

    task automatic check_model();
        int         fl_q[$];
        int         cnt;
        int         navail;
        logic       rdy;
        logic [3:0] fv;
        free_list(fl_q);
        cnt    = fl_q.size();
        rdy    = (cnt >= 4) && !flush;
        navail = (cnt < 4) ? cnt : 4;
        for (int k = 0; k < 4; k++) fv[k] = dec_valid[k] && rdy;
        chk("model free_cnt", 32'(free_cnt), 32'(cnt));
        chk("model alloc_ready", 32'(alloc_ready), 32'(rdy));
        chk("model free_valid", 32'(free_valid), 32'(fv));
        for (int k = 0; k < navail; k++) exp_q.push_back(4'(fl_q[k]));
        for (int k = 0; k < navail; k++) begin
            chk($sformatf("model free_addr[%0d]", k), 32'(free_addr[k]), 32'(exp_q.pop_front()));
        end
        chk("model stall_cycles", stall_cycles, stall_m);
    endtask

    task automatic advance();
        int   fl_q[$];
        logic rdy;
        free_list(fl_q);
        rdy = (fl_q.size() >= 4) && !flush;
        @(posedge clk);
`ifdef IQ_ALLOC_PERF_EN
        if (|dec_valid && !rdy && !flush && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
        if (flush) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
        end else begin
            for (int j = 0; j < 4; j++) if (arbit_grant[j]) busy_m[arbit_addr[j]] = 1'b0;
            for (int k = 0; k < 4; k++) if (dec_valid[k] && rdy) busy_m[fl_q[k]] = 1'b1;
        end
    endtask

    task automatic random_step();
        int          b_q[$];
        logic [3:0]  gv;
        logic [15:0] ga;
        logic        fl;
        gv = '0;
        ga = '0;
        for (int i = 0; i < 16; i++) if (busy_m[i]) b_q.push_back(i);
        for (int j = 0; j < 4; j++) begin
            if (b_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                gv[j]       = 1'b1;
                ga[4*j +: 4] = 4'(b_q[$urandom_range(0, b_q.size() - 1)]);
            end
        end
        fl = ($urandom_range(0, 19) == 0);
        drive(4'($urandom_range(0, 15)), gv, ga, fl);
        check_model();
        advance();
    endtask

    initial begin
        int navail;
        tab[0]  = '{4'h0, 4'h0, 16'h0000, 1'b0, 16, 1'b1, 16'h3210, 4'h0};
        tab[1]  = '{4'hF, 4'h0, 16'h0000, 1'b0, 16, 1'b1, 16'h3210, 4'hF};
        tab[2]  = '{4'h0, 4'h0, 16'h0000, 1'b0, 12, 1'b1, 16'h7654, 4'h0};
        tab[3]  = '{4'hF, 4'h0, 16'h0000, 1'b0, 12, 1'b1, 16'h7654, 4'hF};
        tab[4]  = '{4'hF, 4'h0, 16'h0000, 1'b0,  8, 1'b1, 16'hBA98, 4'hF};
        tab[5]  = '{4'hF, 4'h0, 16'h0000, 1'b0,  4, 1'b1, 16'hFEDC, 4'hF};
        tab[6]  = '{4'hF, 4'h1, 16'h0005, 1'b0,  0, 1'b0, 16'h0000, 4'h0};
        tab[7]  = '{4'h0, 4'h7, 16'h0210, 1'b0,  1, 1'b0, 16'h0005, 4'h0};
        tab[8]  = '{4'h0, 4'h0, 16'h0000, 1'b0,  4, 1'b1, 16'h5210, 4'h0};
        tab[9]  = '{4'hF, 4'h0, 16'h0000, 1'b1,  4, 1'b0, 16'h5210, 4'h0};
        tab[10] = '{4'h5, 4'h0, 16'h0000, 1'b0, 16, 1'b1, 16'h3210, 4'h5};
        tab[11] = '{4'h0, 4'h0, 16'h0000, 1'b0, 14, 1'b1, 16'h5431, 4'h0};
        tab[12] = '{4'hF, 4'h0, 16'h0000, 1'b0, 14, 1'b1, 16'h5431, 4'hF};
        tab[13] = '{4'hF, 4'h0, 16'h0000, 1'b0, 10, 1'b1, 16'h9876, 4'hF};
        tab[14] = '{4'h0, 4'hF, 16'h3210, 1'b0,  6, 1'b1, 16'hDCBA, 4'h0};
        tab[15] = '{4'hF, 4'h1, 16'h0008, 1'b0, 10, 1'b1, 16'h3210, 4'hF};
        tab[16] = '{4'h0, 4'h0, 16'h0000, 1'b0,  7, 1'b1, 16'hCBA8, 4'h0};

        // Clock/reset
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset free_cnt", 32'(free_cnt), 32'd16);
        chk("reset stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (tab[i]) begin
            drive(tab[i].dv, tab[i].gv, tab[i].ga, tab[i].fl);
            navail = (tab[i].cnt < 4) ? tab[i].cnt : 4;
            chk($sformatf("vec%0d free_cnt", i), 32'(free_cnt), 32'(tab[i].cnt));
            chk($sformatf("vec%0d alloc_ready", i), 32'(alloc_ready), 32'(tab[i].rdy));
            chk($sformatf("vec%0d free_valid", i), 32'(free_valid), 32'(tab[i].fv));
            for (int k = 0; k < navail; k++) begin
                chk($sformatf("vec%0d free_addr[%0d]", i, k), 32'(free_addr[k]), 32'(tab[i].addr[4*k +: 4]));
            end
            check_model();
            advance();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) random_step();

        // Reset asserted mid-burst takes effect without a clock edge
        drive(4'hF, 4'h0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst free_cnt", 32'(free_cnt), 32'd16);
        chk("midrst alloc_ready", 32'(alloc_ready), 32'd1);
        chk("midrst free_valid", 32'(free_valid), 32'hF);
        for (int k = 0; k < 4; k++) chk($sformatf("midrst free_addr[%0d]", k), 32'(free_addr[k]), 32'(k));
        chk("midrst stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dec_valid = '0;

        for (int n = 0; n < 200; n++) random_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
